// File: rtl/tpic_loopback_check.sv
// Watches the TPIC daisy-chain: every bit leaving the chain end must equal the bit that
// entered CHAIN_BITS sclks earlier, and every frame must be exactly CHAIN_BITS sclks long.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | disabled; status outputs and delay line hold
// WAIT_RCK | enabled; discard the partial frame until the next rck rise
// SHIFT    | in a frame; shift/compare one bit per sclk rise
// EVAL     | one clk; publish frame status and clear the accumulators
module tpic_loopback_check #(
    parameter int CHAIN_BITS = 432,
    parameter int IDX_W      = 9,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tpic_sclk,
    input  logic             tpic_rck,
    input  logic             tpic_sout,
    input  logic             tpic_miso,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             len_err,
    output logic             primed,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] frame_cnt
);

    // bit_cnt is one bit wider than IDX_W so it can reach CHAIN_BITS+1 for any legal IDX_W
    localparam logic [IDX_W:0] LEN     = (IDX_W+1)'(CHAIN_BITS);
    localparam logic [IDX_W:0] LEN_SAT = (IDX_W+1)'(CHAIN_BITS + 1);

    typedef enum logic [1:0] {IDLE, WAIT_RCK, SHIFT, EVAL} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              sclk_sync, rck_sync;
    logic [1:0]              sout_sync, miso_sync;
    logic                    sclk_rise, rck_rise, sout_d, miso_d;
    logic [CHAIN_BITS-1:0]   hist;
    logic [IDX_W:0]          bit_cnt;
    logic [CNT_W-1:0]        err_cnt;
    logic [IDX_W-1:0]        err_idx;
    logic                    len_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            rck_sync  <= '0;
            sout_sync <= '0;
            miso_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], tpic_sclk};
            rck_sync  <= {rck_sync[1:0], tpic_rck};
            sout_sync <= {sout_sync[0], tpic_sout};
            miso_sync <= {miso_sync[0], tpic_miso};
        end
    end

    // data is taken from the same stage that produces the sclk edge
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign rck_rise  = rck_sync[1] & ~rck_sync[2];
    assign sout_d    = sout_sync[1];
    assign miso_d    = miso_sync[1];
    assign len_bad   = (bit_cnt != LEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable)   state_nxt = WAIT_RCK;
            WAIT_RCK: if (rck_rise) state_nxt = SHIFT;
            SHIFT:    if (rck_rise) state_nxt = EVAL;
            EVAL:                   state_nxt = SHIFT;
            default:                state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist          <= '0;
            bit_cnt       <= '0;
            err_cnt       <= '0;
            err_idx       <= '1;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            len_err       <= 1'b0;
            primed        <= 1'b0;
            mismatch_cnt  <= '0;
            first_err_idx <= '1;
            frame_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!enable || state == WAIT_RCK) begin
                bit_cnt <= '0;
                err_cnt <= '0;
                err_idx <= '1;
            end else if (state == SHIFT) begin
                if (sclk_rise) begin
                    if (primed && (bit_cnt < LEN) && (miso_d != hist[CHAIN_BITS-1])) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                        if (err_cnt == '0) err_idx <= bit_cnt[IDX_W-1:0];
                    end
                    hist <= {hist[CHAIN_BITS-2:0], sout_d};
                    if (bit_cnt != LEN_SAT) bit_cnt <= bit_cnt + (IDX_W+1)'(1);
                end
            end else if (state == EVAL) begin
                // status lands together with the frame_done pulse
                frame_done    <= 1'b1;
                len_err       <= len_bad;
                frame_ok      <= primed & ~len_bad & (err_cnt == '0);
                mismatch_cnt  <= err_cnt;
                first_err_idx <= err_idx;
                frame_cnt     <= frame_cnt + CNT_W'(1);
                primed        <= ~len_bad;
                bit_cnt       <= '0;
                err_cnt       <= '0;
                err_idx       <= '1;
            end
        end
    end

endmodule

// File: tb/tb_tpic_loopback_check.sv
// Randomized loopback bench: a queue-based chain/checker model predicts each frame's status,
// a monitor compares it whenever frame_done pulses.
module tb_tpic_loopback_check;
    localparam int N = 432;

    logic        clk = 1'b0;
    logic        reset, enable, sclk, rck, sout, miso;
    logic        frame_done, frame_ok, len_err, primed;
    logic [15:0] mismatch_cnt, frame_cnt;
    logic [8:0]  first_err_idx;

    tpic_loopback_check #(.CHAIN_BITS(N), .IDX_W(9), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .tpic_sclk(sclk), .tpic_rck(rck), .tpic_sout(sout), .tpic_miso(miso),
        .frame_done(frame_done), .frame_ok(frame_ok), .len_err(len_err), .primed(primed),
        .mismatch_cnt(mismatch_cnt), .first_err_idx(first_err_idx), .frame_cnt(frame_cnt)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit ok; bit le; bit pr; int mm; int idx; int fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   chain[$];   // physical TPIC chain contents
    bit   rec[$];     // last N bits the checker has captured
    bit   m_en, m_in_frame, m_primed;
    int   m_cnt, m_errs, m_first, m_fcnt;
    int   total = 0, bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rec.delete();
        for (int i = 0; i < N; i++) rec.push_back(1'b0);
        m_in_frame = 0; m_primed = 0; m_cnt = 0; m_errs = 0; m_first = 0; m_fcnt = 0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_frame_done: got 1 expected 0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("frame_ok", int'(frame_ok), int'(mon_e.ok));
                check("len_err", int'(len_err), int'(mon_e.le));
                check("primed", int'(primed), int'(mon_e.pr));
                check("mismatch_cnt", int'(mismatch_cnt), mon_e.mm);
                check("first_err_idx", int'(first_err_idx), mon_e.idx);
                check("frame_cnt", int'(frame_cnt), mon_e.fc);
            end
        end
    end

    // mode 0: random sout through the loopback; mode 1: sout all ones, miso stuck low
    task automatic send_bit(input bit s, input bit inj, input int mode);
        bit m;
        m = chain.pop_front() ^ inj;
        if (mode == 1) m = 1'b0;
        chain.push_back(s);
        if (m_en && m_in_frame) begin
            if (m_primed && m_cnt < N && m != rec[0]) begin
                if (m_errs == 0) m_first = m_cnt;
                m_errs++;
            end
            void'(rec.pop_front());
            rec.push_back(s);
            if (m_cnt < N + 1) m_cnt++;
        end
        @(negedge clk);
        sout = s; miso = m; sclk = 1'b0;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input int n, input int mode, input int inj_idx);
        for (int i = 0; i < n; i++)
            send_bit(mode == 1 ? 1'b1 : 1'($urandom), i == inj_idx, mode);
    endtask

    task automatic send_rck();
        exp_t e;
        if (m_en) begin
            if (m_in_frame) begin
                e.le = (m_cnt != N);
                e.ok = m_primed && !e.le && m_errs == 0;
                e.mm = m_errs;
                e.idx = (m_errs != 0) ? m_first : 511;
                m_fcnt++;
                e.fc = m_fcnt % 65536;
                m_primed = !e.le;
                e.pr = m_primed;
                sb.push_back(e);
            end
            m_in_frame = 1; m_cnt = 0; m_errs = 0;
        end
        @(negedge clk);
        sclk = 1'b0; rck = 1'b1;
        repeat (4) @(negedge clk);
        rck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input int n, input int mode, input int inj_idx);
        send_bits(n, mode, inj_idx);
        send_rck();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; sclk = 1'b0; rck = 1'b0; sout = 1'b0; miso = 1'b0;
        for (int i = 0; i < N; i++) chain.push_back(1'b0);
        model_reset();
        m_en = 0;
        repeat (5) @(negedge clk);
        check("rst_first_err_idx", int'(first_err_idx), 511);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        reset = 1'b1;
        enable = 1'b1; m_en = 1;
        repeat (3) @(negedge clk);

        // clean loopback: first frame primes, next two pass
        send_rck();
        frame(N, 0, -1);
        frame(N, 0, -1);
        frame(N, 0, -1);
        // single flipped bit
        frame(N, 0, 17);
        // short frame unprimes, next full frame re-primes, then passes
        frame(N - 1, 0, -1);
        frame(N, 0, -1);
        frame(N, 0, -1);
        // stuck-low return with all-ones data
        frame(N, 1, -1);
        frame(N, 1, -1);
        // disable mid-frame: status holds, partial frame discarded
        send_bits(200, 0, -1);
        @(negedge clk);
        enable = 1'b0; m_en = 0; m_in_frame = 0;
        repeat (10) @(negedge clk);
        check("hold_frame_cnt", int'(frame_cnt), m_fcnt);
        check("hold_primed", int'(primed), int'(m_primed));
        enable = 1'b1; m_en = 1;
        send_bits(N - 200, 0, -1);
        send_rck();
        frame(N, 0, -1);
        frame(N, 0, -1);
        // random lengths and single-bit faults
        for (int k = 0; k < 3; k++)
            frame(N - 2 + int'($urandom_range(0, 4)), 0,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        // asynchronous reset in the middle of a frame
        send_bits(50, 0, -1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_frame_done", int'(frame_done), 0);
        check("arst_frame_ok", int'(frame_ok), 0);
        check("arst_len_err", int'(len_err), 0);
        check("arst_primed", int'(primed), 0);
        check("arst_mismatch_cnt", int'(mismatch_cnt), 0);
        check("arst_first_err_idx", int'(first_err_idx), 511);
        check("arst_frame_cnt", int'(frame_cnt), 0);
        model_reset();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
